// File: rtl/pe_gen.sv
// Row-stationary PE: holds p filter rows and an S-tap ifmap window, runs one signed 8x8 MAC per cycle.
// Optional PE_RELU_EN clamps negative opsum values to zero on the output port only.
module pe_gen #(
  parameter int DATA_BITS = 32,
  parameter int LANES     = 4,
  parameter int S         = 3,
  parameter int MAX_P     = 4,
  parameter int PSUM_BITS = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 PE_en,
  input  logic [9:0]           i_config,
  input  logic [DATA_BITS-1:0] ifmap,
  input  logic                 ifmap_valid,
  output logic                 ifmap_ready,
  input  logic [DATA_BITS-1:0] filter,
  input  logic                 filter_valid,
  output logic                 filter_ready,
  input  logic [PSUM_BITS-1:0] ipsum,
  input  logic                 ipsum_valid,
  output logic                 ipsum_ready,
  output logic [PSUM_BITS-1:0] opsum,
  output logic                 opsum_valid,
  input  logic                 opsum_ready,
  output logic                 busy,
  output logic                 done
);
  localparam int PW = $clog2(MAX_P + 1);
  localparam int QW = $clog2(LANES + 1);
  localparam int SW = $clog2(S + 1);
  localparam int NF = MAX_P * S;
  localparam int CW = $clog2(NF + 1);

  typedef enum logic [2:0] {
    IDLE, LOAD_FILT, LOAD_IFMAP, COMPUTE, LOAD_IPSUM, OUTPUT, SLIDE, LOAD_SLIDE
  } state_t;

  typedef struct packed {
    logic          mode;
    logic [PW-1:0] p;
    logic [QW-1:0] q;
    logic [4:0]    f;
  } cfg_t;

  state_t               state;
  cfg_t                 cfg, cfg_n;
  logic [CW-1:0]        cnt;
  logic [PW-1:0]        k_i;
  logic [SW-1:0]        s_i;
  logic [QW-1:0]        c_i;
  logic [4:0]           win;
  logic [DATA_BITS-1:0] filt [NF];
  logic [DATA_BITS-1:0] ifm  [S];
  logic [PSUM_BITS-1:0] psum [MAX_P];

  int                   p_dec, q_dec;
  logic [CW-1:0]        f_addr;
  logic [DATA_BITS-1:0] f_word, i_word;
  logic signed [7:0]    a_s, b_s;
  logic signed [15:0]   prod;
  logic [PSUM_BITS-1:0] prod_x;
  logic                 c_last, s_last, k_last;

  // out-of-range p/q saturate to the hardware limits; f=0 behaves as one window
  always_comb begin
    p_dec = int'(i_config[8:7]) + 1;
    q_dec = int'(i_config[1:0]) + 1;
    if (p_dec > MAX_P) p_dec = MAX_P;
    if (q_dec > LANES) q_dec = LANES;
    cfg_n.mode = i_config[9];
    cfg_n.p    = PW'(p_dec);
    cfg_n.q    = QW'(q_dec);
    cfg_n.f    = (i_config[6:2] == 5'd0) ? 5'd1 : i_config[6:2];
  end

  // ifmap bytes arrive offset-binary; flipping the MSB yields two's complement
  always_comb begin
    f_addr = CW'(int'(k_i) * S + int'(s_i));
    f_word = filt[f_addr];
    i_word = ifm[s_i];
    a_s    = signed'(i_word[int'(c_i)*8 +: 8] ^ 8'h80);
    b_s    = signed'(f_word[int'(c_i)*8 +: 8]);
    prod   = a_s * b_s;
    prod_x = {{(PSUM_BITS-16){prod[15]}}, prod};
    c_last = (c_i == QW'(cfg.q - 1'b1));
    s_last = (s_i == SW'(S - 1));
    k_last = (k_i == PW'(cfg.p - 1'b1));
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= IDLE;
      cfg   <= '0;
      cnt   <= '0;
      k_i   <= '0;
      s_i   <= '0;
      c_i   <= '0;
      win   <= '0;
      done  <= 1'b0;
      for (int i = 0; i < NF; i++)    filt[i] <= '0;
      for (int i = 0; i < S; i++)     ifm[i]  <= '0;
      for (int i = 0; i < MAX_P; i++) psum[i] <= '0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: if (PE_en) begin
          cfg   <= cfg_n;
          cnt   <= '0;
          win   <= '0;
          state <= LOAD_FILT;
        end
        LOAD_FILT: if (filter_valid) begin
          filt[cnt] <= filter;
          if (cnt == CW'(int'(cfg.p) * S - 1)) begin
            cnt   <= '0;
            state <= LOAD_IFMAP;
          end else cnt <= cnt + 1'b1;
        end
        LOAD_IFMAP: if (ifmap_valid) begin
          ifm[cnt] <= ifmap;
          if (cnt == CW'(S - 1)) begin
            cnt   <= '0;
            k_i   <= '0;
            s_i   <= '0;
            c_i   <= '0;
            for (int i = 0; i < MAX_P; i++) psum[i] <= '0;
            state <= COMPUTE;
          end else cnt <= cnt + 1'b1;
        end
        COMPUTE: begin
          psum[k_i] <= psum[k_i] + prod_x;
          if (!c_last) c_i <= c_i + 1'b1;
          else begin
            c_i <= '0;
            if (!s_last) s_i <= s_i + 1'b1;
            else begin
              s_i <= '0;
              if (!k_last) k_i <= k_i + 1'b1;
              else begin
                k_i   <= '0;
                cnt   <= '0;
                state <= cfg.mode ? OUTPUT : LOAD_IPSUM;
              end
            end
          end
        end
        LOAD_IPSUM: if (ipsum_valid) begin
          psum[cnt] <= psum[cnt] + ipsum;
          if (cnt == CW'(cfg.p - 1'b1)) begin
            cnt   <= '0;
            state <= OUTPUT;
          end else cnt <= cnt + 1'b1;
        end
        OUTPUT: if (opsum_ready) begin
          if (cnt == CW'(cfg.p - 1'b1)) begin
            cnt <= '0;
            if (5'(win + 5'd1) == cfg.f) begin
              state <= IDLE;
              done  <= 1'b1;
            end else begin
              win   <= win + 5'd1;
              state <= SLIDE;
            end
          end else cnt <= cnt + 1'b1;
        end
        SLIDE: begin
          for (int i = 0; i < S - 1; i++) ifm[i] <= ifm[i+1];
          state <= LOAD_SLIDE;
        end
        LOAD_SLIDE: if (ifmap_valid) begin
          ifm[S-1] <= ifmap;
          k_i      <= '0;
          s_i      <= '0;
          c_i      <= '0;
          for (int i = 0; i < MAX_P; i++) psum[i] <= '0;
          state    <= COMPUTE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign filter_ready = (state == LOAD_FILT);
  assign ifmap_ready  = (state == LOAD_IFMAP) || (state == LOAD_SLIDE);
  assign ipsum_ready  = (state == LOAD_IPSUM);
  assign opsum_valid  = (state == OUTPUT);
  assign busy         = (state != IDLE);

  always_comb begin
    opsum = '0;
    if (state == OUTPUT) begin
`ifdef PE_RELU_EN
      opsum = psum[cnt][PSUM_BITS-1] ? '0 : psum[cnt];
`else
      opsum = psum[cnt];
`endif
    end
  end
endmodule

// File: tb/tb_pe_gen.sv
// Self-checking bench for pe_gen: directed cases plus random jobs against a dot-product reference model.
module tb_pe_gen;
  localparam int S = 3;

  logic        clk = 1'b0;
  logic        rst, PE_en;
  logic [9:0]  i_config;
  logic [31:0] ifmap, filter, ipsum, opsum;
  logic        ifmap_valid, ifmap_ready, filter_valid, filter_ready;
  logic        ipsum_valid, ipsum_ready, opsum_valid, opsum_ready;
  logic        busy, done;

  int total = 0;
  int bad   = 0;
  bit noise = 0;

  logic [31:0] fw  [0:15];
  logic [31:0] iw  [0:39];
  logic [31:0] ipw [0:7][0:3];

  pe_gen dut (
    .clk(clk), .rst(rst), .PE_en(PE_en), .i_config(i_config),
    .ifmap(ifmap), .ifmap_valid(ifmap_valid), .ifmap_ready(ifmap_ready),
    .filter(filter), .filter_valid(filter_valid), .filter_ready(filter_ready),
    .ipsum(ipsum), .ipsum_valid(ipsum_valid), .ipsum_ready(ipsum_ready),
    .opsum(opsum), .opsum_valid(opsum_valid), .opsum_ready(opsum_ready),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  initial begin
    #3000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // window w uses ifmap words w..w+S-1; lanes >= q do not contribute
  function automatic logic [31:0] model(input int k, input int w, input bit mode, input int q);
    int acc = 0;
    for (int s = 0; s < S; s++)
      for (int c = 0; c < q; c++) begin
        byte a, b;
        a = byte'(iw[w+s][c*8 +: 8] ^ 8'h80);
        b = byte'(fw[k*S+s][c*8 +: 8]);
        acc += int'(a) * int'(b);
      end
    if (!mode) acc += int'(ipw[w][k]);
`ifdef PE_RELU_EN
    if (acc < 0) acc = 0;
`endif
    return acc;
  endfunction

  task automatic clear_data();
    for (int i = 0; i < 16; i++) fw[i] = '0;
    for (int i = 0; i < 40; i++) iw[i] = '0;
    for (int i = 0; i < 8; i++) for (int k = 0; k < 4; k++) ipw[i][k] = '0;
  endtask

  task automatic rand_data();
    for (int i = 0; i < 16; i++) fw[i] = $urandom;
    for (int i = 0; i < 40; i++) iw[i] = $urandom;
    for (int i = 0; i < 8; i++) for (int k = 0; k < 4; k++) ipw[i][k] = $urandom;
  endtask

  // sel: 0 filter, 1 ifmap, 2 ipsum
  task automatic push(input int sel, input logic [31:0] w);
    int n = 0;
    logic r;
    repeat ($urandom_range(0, 2)) @(posedge clk);
    @(posedge clk); #1;
    if (noise) begin PE_en = 1'b1; i_config = 10'($urandom); end
    case (sel)
      0: begin filter = w; filter_valid = 1'b1; end
      1: begin ifmap  = w; ifmap_valid  = 1'b1; end
      default: begin ipsum = w; ipsum_valid = 1'b1; end
    endcase
    @(negedge clk);
    r = (sel == 0) ? filter_ready : (sel == 1) ? ifmap_ready : ipsum_ready;
    while (!r && n < 200) begin
      n++;
      @(negedge clk);
      r = (sel == 0) ? filter_ready : (sel == 1) ? ifmap_ready : ipsum_ready;
    end
    chk("push_ready", r, 1'b1);
    @(posedge clk); #1;
    filter_valid = 1'b0; ifmap_valid = 1'b0; ipsum_valid = 1'b0; PE_en = 1'b0;
  endtask

  // counts cycles from the last operand load until the post-MAC handshake opens
  task automatic wait_cmp(input bit mode, input int exp_n);
    int n = 0;
    @(negedge clk);
    while (!(mode ? opsum_valid : ipsum_ready) && n < 2000) begin
      n++;
      @(negedge clk);
    end
    chk("compute_cycles", n, exp_n);
  endtask

  task automatic collect(input int p, input int w, input int q, input bit mode, input int stall);
    int got = 0, n = 0, st = stall;
    while (got < p && n < 500) begin
      @(posedge clk); #1;
      if (st > 0) begin opsum_ready = 1'b0; st--; end
      else opsum_ready = ($urandom_range(0, 2) != 0);
      @(negedge clk);
      chk("opsum_valid", opsum_valid, 1'b1);
      chk("opsum", opsum, model(got, w, mode, q));
      if (opsum_ready) got++;
      n++;
    end
    chk("opsum_count", got, p);
  endtask

  task automatic start(input bit mode, input int p, input int q, input int f);
    @(posedge clk); #1;
    i_config = {mode, 2'(p-1), 5'(f), 2'(q-1)};
    PE_en = 1'b1;
    @(posedge clk); #1;
    PE_en = 1'b0;
    @(negedge clk);
    chk("busy_start", busy, 1'b1);
  endtask

  task automatic run_job(input bit mode, input int p, input int q, input int f, input int stall);
    int fe = (f == 0) ? 1 : f;
    start(mode, p, q, f);
    for (int i = 0; i < p*S; i++) push(0, fw[i]);
    for (int s = 0; s < S; s++) push(1, iw[s]);
    for (int w = 0; w < fe; w++) begin
      if (w > 0) push(1, iw[S-1+w]);
      wait_cmp(mode, p*S*q);
      if (!mode) for (int k = 0; k < p; k++) push(2, ipw[w][k]);
      collect(p, w, q, mode, (w == 0) ? stall : 0);
      @(posedge clk); #1;
      opsum_ready = 1'b0;
      @(negedge clk);
      chk("done", done, (w == fe-1));
      chk("busy_end", busy, (w != fe-1));
      if (w == fe-1) begin
        @(negedge clk);
        chk("done_pulse", done, 1'b0);
      end
    end
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_busy"}, busy, 1'b0);
    chk({tag, "_done"}, done, 1'b0);
    chk({tag, "_frdy"}, filter_ready, 1'b0);
    chk({tag, "_irdy"}, ifmap_ready, 1'b0);
    chk({tag, "_prdy"}, ipsum_ready, 1'b0);
    chk({tag, "_ovld"}, opsum_valid, 1'b0);
    chk({tag, "_opsum"}, opsum, 32'h0);
  endtask

  task automatic set_basic();
    clear_data();
    fw[0] = 32'd1; fw[1] = 32'd2; fw[2] = 32'd3;
    iw[0] = 32'h81; iw[1] = 32'h82; iw[2] = 32'h83; iw[3] = 32'h84;
    ipw[0][0] = 32'd10;
  endtask

  initial begin
    rst = 1'b0; PE_en = 1'b0; i_config = '0;
    ifmap = '0; filter = '0; ipsum = '0;
    ifmap_valid = 1'b0; filter_valid = 1'b0; ipsum_valid = 1'b0; opsum_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_idle("reset");
    rst = 1'b1;
    @(negedge clk);
    chk_idle("post_reset");

    // single filter, single lane, accumulate ipsum: 14 + 10
    set_basic();
    run_job(1'b0, 1, 1, 1, 0);

    // two windows, sliding in 0x84
    set_basic();
    run_job(1'b1, 1, 1, 2, 0);

    // output back-pressure with two entries
    rand_data();
    run_job(1'($urandom_range(0, 1)), 2, 3, 1, 5);

    // q=2 with live upper lanes
    rand_data();
    for (int i = 0; i < 16; i++) fw[i] = fw[i] | 32'h0101_0000;
    run_job(1'b1, 2, 2, 1, 0);

    // negative result: raw wrap vs clamp
    clear_data();
    fw[0] = 32'hFF; fw[1] = 32'hFE; fw[2] = 32'hFD;
    iw[0] = 32'h81; iw[1] = 32'h82; iw[2] = 32'h83;
    run_job(1'b1, 1, 1, 1, 0);

    // reset in the middle of a long compute
    rand_data();
    start(1'b1, 4, 4, 1);
    for (int i = 0; i < 4*S; i++) push(0, fw[i]);
    for (int s = 0; s < S; s++) push(1, iw[s]);
    repeat (10) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    chk_idle("mid_reset");
    set_basic();
    run_job(1'b0, 1, 1, 1, 0);

    // random jobs with stray PE_en while busy
    noise = 1;
    for (int j = 0; j < 8; j++) begin
      rand_data();
      run_job(1'($urandom_range(0, 1)), $urandom_range(1, 4), $urandom_range(1, 4),
              $urandom_range(0, 3), $urandom_range(0, 3));
    end
    noise = 0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/pe_gen.md
PE_GEN -- requirements
Module: pe_gen

Interface
REQ-001 SHALL have parameter DATA_BITS, default 32, bus word width (LANES x 8-bit elements).
REQ-002 SHALL have parameter LANES, default 4, channel lanes per bus word (DATA_BITS/8).
REQ-003 SHALL have parameter S, default 3, filter taps per row.
REQ-004 SHALL have parameter MAX_P, default 4, maximum filters (psum entries).
REQ-005 SHALL have parameter PSUM_BITS, default 32, psum/opsum width.
REQ-006 SHALL have port clk  input  1  the single clock.
REQ-007 SHALL have port rst  input  1  synchronous, active-low reset.
REQ-008 SHALL have port PE_en  input  1  start request; config sampled when asserted in IDLE.
REQ-009 SHALL have port i_config  input  10  {mode[9], p-1[8:7], f[6:2], q-1[1:0]}.
REQ-010 SHALL have ports ifmap, filter  input  DATA_BITS  and ipsum  input  PSUM_BITS, each with input valid / output ready.
REQ-011 SHALL have port opsum  output  PSUM_BITS  with output opsum_valid / input opsum_ready.
REQ-012 SHALL have ports busy, done  output  1  busy high whenever not IDLE; done a one-cycle pulse on return to IDLE.

Function
REQ-013 SHALL implement states IDLE, LOAD_FILT, LOAD_IFMAP, COMPUTE, LOAD_IPSUM, OUTPUT, SLIDE, LOAD_SLIDE.
REQ-014 SHALL transfer a word only in a cycle where valid && ready; ready is decoded from state only: filter_ready in LOAD_FILT, ifmap_ready in LOAD_IFMAP/LOAD_SLIDE, ipsum_ready in LOAD_IPSUM; deasserted valid stalls indefinitely.
REQ-015 SHALL on PE_en in IDLE latch p, q, f and mode and enter LOAD_FILT; PE_en outside IDLE is ignored.
REQ-016 SHALL accept p*S filter words (filter k, tap s at word k*S+s), then S ifmap words (tap 0 first), then enter COMPUTE.
REQ-017 SHALL convert ifmap bytes to signed by XOR 0x80; filter bytes are signed int8.
REQ-018 SHALL spend exactly p*S*q cycles in COMPUTE, one signed 8x8 MAC per cycle, producing psum[k] = sum over s<S, c<q of ifmap[s][c]*filter[k][s][c]; lanes c>=q are ignored.
REQ-019 SHALL clear all psum entries on entry to COMPUTE.
REQ-020 SHALL, with mode=0, after COMPUTE accept p ipsum words into LOAD_IPSUM, adding word k to psum[k]; with mode=1, skip LOAD_IPSUM.
REQ-021 SHALL in OUTPUT present psum[0..p-1] in order, advancing only on opsum_valid && opsum_ready; opsum is held stable while stalled.
REQ-022 SHALL count windows; after the last OUTPUT word, if windows == max(f,1), go to IDLE with done; else go to SLIDE.
REQ-023 SHALL in SLIDE (1 cycle) shift ifmap taps s<-s+1, then in LOAD_SLIDE accept one word into tap S-1, then enter COMPUTE; filters are retained.
REQ-024 SHALL wrap psum arithmetic modulo 2^PSUM_BITS with no saturation.
REQ-025 SHALL treat p>MAX_P as MAX_P and q>LANES as LANES.

Reset
REQ-026 SHALL, while rst==0 at a clock edge, enter IDLE from any state (including mid-COMPUTE) and clear all spads, counters and latched config.
REQ-027 SHALL drive all ready outputs, opsum_valid, busy and done to 0, and opsum to 0, during and after reset.

Configuration
REQ-028 SHALL, with PE_RELU_EN defined, output opsum = psum if psum is non-negative, else 0; without PE_RELU_EN, output the raw psum; internal psum state is unaffected in either case.

Verification
REQ-029 SHALL cover p=1, q=1, f=1, mode=0: filter lane0 = 1,2,3; ifmap lane0 = 0x81,0x82,0x83; ipsum = 10 -> opsum = 24, then done.
REQ-030 SHALL cover the same filter with f=2, mode=1: window 1 gives 14; slide word 0x84 gives a second opsum of 20; one done pulse only.
REQ-031 SHALL cover opsum_ready low for 5 cycles in OUTPUT, p=2 -> opsum_valid stays high, opsum is unchanged, and no entry is skipped or duplicated.
REQ-032 SHALL cover q=2 with nonzero lanes 2-3 -> result equals the lanes 0-1 dot product only, and COMPUTE lasts p*S*2 cycles.
REQ-033 SHALL cover filter = -1,-2,-3 and ifmap 1,2,3, mode=1 -> opsum = 0 with PE_RELU_EN, 0xFFFFFFF2 without it.
REQ-034 SHALL cover rst low for one cycle mid-COMPUTE -> next cycle IDLE, busy=0, all readies=0; a subsequent PE_en run reproduces the REQ-029 result.
